pkt_rr_arbiter: RTL and testbench
=================================

// Module: pkt_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter/mux: merges NUM_IN Avalon-ST packet streams into one stream
//  feeding a shared unified_pkt_fifo. Grant locks on SOP and holds until the EOP beat is accepted.
//  New packets are gated on the FIFO almost_full flag when USE_ALMOST_FULL=1.
//  Single registered output stage; sits between the per-lane producers and the shared FIFO.
// PARAMETERS
//  NUM_IN            4    number of requesters (>=2)
//  SYMBOLS_PER_BEAT  64   symbols per beat; EW = $clog2(SYMBOLS_PER_BEAT)
//  BITS_PER_SYMBOL   8    bits per symbol; DW = SYMBOLS_PER_BEAT*BITS_PER_SYMBOL
//  USE_ALMOST_FULL   0    1: block new-packet grants while out_almost_full; 0: ignore out_almost_full
// PORTS
//  clk               in   1           clock
//  rst               in   1           synchronous reset, active high
//  in_data           in   NUM_IN*DW   lane i at [i*DW +: DW]
//  in_valid          in   NUM_IN      per-lane valid
//  in_ready          out  NUM_IN      per-lane ready (at most one bit high)
//  in_startofpacket  in   NUM_IN      per-lane SOP
//  in_endofpacket    in   NUM_IN      per-lane EOP
//  in_empty          in   NUM_IN*EW   lane i at [i*EW +: EW]
//  out_data          out  DW          registered data
//  out_valid         out  1           registered valid
//  out_ready         in   1           downstream ready (FIFO in_ready)
//  out_startofpacket out  1           registered SOP
//  out_endofpacket   out  1           registered EOP
//  out_empty         out  EW          registered empty
//  out_src           out  SW          source lane of the current out beat; SW = max(1,$clog2(NUM_IN))
//  out_almost_full   in   1           FIFO almost_full
//  proto_err         out  1           sticky SOP/EOP framing error flag
// BEHAVIOUR
//  Reset: out_valid=0, out_sop/eop=0, out_data/out_empty/out_src=0, proto_err=0, state=IDLE, rr_ptr=NUM_IN-1.
//  load = !out_valid | out_ready. On load, the output register takes the accepted beat (out_valid=1) or
//    clears out_valid if no beat was accepted. Latency: input accept -> out_valid = 1 cycle. Full throughput.
//  States: IDLE (no grant held) and LOCKED (lock_src holds the grant).
//  IDLE: pick = first lane with in_valid, searching rr_ptr+1, rr_ptr+2, ... (mod NUM_IN).
//    gate = USE_ALMOST_FULL & out_almost_full. in_ready[pick] = load & !gate; all other lanes 0.
//    Accepted beat with !eop -> LOCKED, lock_src=pick. Accepted beat with eop (1-beat pkt) -> stay IDLE, rr_ptr=pick.
//    Accepted beat without sop: forwarded, treated as a packet start, proto_err<=1.
//  LOCKED: in_ready[lock_src] = load; almost_full is ignored (FIFO FULL_LEVEL slack absorbs the packet tail).
//    Accepted eop -> IDLE, rr_ptr=lock_src. Accepted sop mid-packet: forwarded, proto_err<=1, state unchanged.
//    Other lanes' in_valid are ignored; lock_src in_valid=0 -> bubble, lock held.
//  in_ready is combinational from state, in_valid, out_valid, out_ready and out_almost_full.
//    There is no combinational path from in_data.
//  Fairness: after lane k's EOP, lane k is lowest priority; a lane with a waiting packet is granted within NUM_IN-1 packets.
//  out_src = lane index of the beat in the output register.
//  proto_err: cleared only by rst.
//  rst mid-packet: lock dropped and output register cleared; the truncated packet is not completed.
//    Downstream must tolerate a truncated packet on reset.
// TESTING
//  1. Reset, lanes 0..3 each hold one 3-beat pkt ->
//     out order lanes 0,1,2,3; beats contiguous per pkt; out_src matches; 12 beats in 12 cycles with out_ready=1.
//  2. Lane 1 mid-pkt (beat 2 of 4), lane 0 raises a pkt ->
//     lane 0 in_ready=0 until lane 1 EOP accepted; lane 0 granted the next cycle; no interleaving.
//  3. USE_ALMOST_FULL=1, out_almost_full=1 in IDLE ->
//     all in_ready=0. Assert out_almost_full mid-packet -> lane still completes to EOP, then grants stop.
//  4. out_ready toggles 1,0,0,1 during a 5-beat pkt ->
//     out_data held stable while out_valid & !out_ready; no beat lost or duplicated.
//  5. Lane 2 sends beat with eop, no sop, in IDLE -> beat forwarded, proto_err=1 and stays 1.
//     SOP beat inside a pkt -> proto_err=1, lock unchanged.
//  6. Reset asserted at beat 2 of a 4-beat pkt -> next cycle out_valid=0, all in_ready=0.
//     After release, rr_ptr=NUM_IN-1 and lane 0 wins first.

Source files
------------

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_IN Avalon-ST lanes.
// Grant locks on the first accepted beat and releases on EOP.
module pkt_rr_arbiter #(
  parameter int NUM_IN           = 4,
  parameter int SYMBOLS_PER_BEAT = 64,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int USE_ALMOST_FULL  = 0,
  localparam int DW = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL,
  localparam int EW = $clog2(SYMBOLS_PER_BEAT),
  localparam int SW = ($clog2(NUM_IN) > 0) ? $clog2(NUM_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN*DW-1:0] in_data,
  input  logic [NUM_IN-1:0]    in_valid,
  output logic [NUM_IN-1:0]    in_ready,
  input  logic [NUM_IN-1:0]    in_startofpacket,
  input  logic [NUM_IN-1:0]    in_endofpacket,
  input  logic [NUM_IN*EW-1:0] in_empty,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [EW-1:0]        out_empty,
  output logic [SW-1:0]        out_src,
  input  logic                 out_almost_full,
  output logic                 proto_err
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t      state, state_n;
  logic [SW-1:0] rr_ptr, rr_n;
  logic [SW-1:0] lock_src, lock_n;
  logic [SW-1:0] pick, sel;
  logic          pick_ok;
  logic          load, gate, grant, accept;
  logic          sel_sop, sel_eop;
  logic          err_set;

  assign load = !out_valid || out_ready;
  assign gate = (USE_ALMOST_FULL != 0) && out_almost_full;

  // Rotating-priority search starting just after the last lane served.
  always_comb begin
    int idx;
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_IN;
      if (!pick_ok && in_valid[idx]) begin
        pick    = SW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  assign sel     = (state == LOCKED) ? lock_src : pick;
  assign sel_sop = in_startofpacket[sel];
  assign sel_eop = in_endofpacket[sel];

  // A held lock ignores almost_full so the packet tail always drains.
  always_comb begin
    grant = 1'b0;
    unique case (state)
      IDLE:    grant = pick_ok && load && !gate;
      LOCKED:  grant = load;
      default: grant = 1'b0;
    endcase
  end

  assign in_ready = grant ? (NUM_IN'(1) << sel) : '0;
  assign accept   = grant && in_valid[sel];

  // Next-state, lock owner, round-robin pointer and framing-error detect.
  always_comb begin
    state_n = state;
    lock_n  = lock_src;
    rr_n    = rr_ptr;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          err_set = !sel_sop;
          if (sel_eop) begin
            rr_n = pick;
          end else begin
            state_n = LOCKED;
            lock_n  = pick;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          err_set = sel_sop;
          if (sel_eop) begin
            state_n = IDLE;
            rr_n    = lock_src;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= SW'(NUM_IN - 1);
      lock_src  <= '0;
      proto_err <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      lock_src <= lock_n;
      if (err_set) proto_err <= 1'b1;
    end
  end

  // Single output register stage, refilled whenever it is empty or drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      out_src           <= '0;
    end else if (load) begin
      out_valid <= accept;
      if (accept) begin
        out_data          <= in_data[int'(sel)*DW +: DW];
        out_startofpacket <= sel_sop;
        out_endofpacket   <= sel_eop;
        out_empty         <= in_empty[int'(sel)*EW +: EW];
        out_src           <= sel;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Bench for pkt_rr_arbiter: lane queues drive stimulus, accepted beats
// are queued as expectations and matched against the output stream.
module tb_pkt_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int SW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] emp;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    in_startofpacket;
  logic [N-1:0]    in_endofpacket;
  logic [N*EW-1:0] in_empty;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_startofpacket;
  logic            out_endofpacket;
  logic [EW-1:0]   out_empty;
  logic [SW-1:0]   out_src;
  logic            out_almost_full;
  logic            proto_err;

  pkt_rr_arbiter #(
    .NUM_IN(N),
    .SYMBOLS_PER_BEAT(4),
    .BITS_PER_SYMBOL(8),
    .USE_ALMOST_FULL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .in_empty(in_empty),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket),
    .out_empty(out_empty),
    .out_src(out_src),
    .out_almost_full(out_almost_full),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  beat_t        lane_q[N][$];
  logic [63:0]  sb[$];
  int           src_log[$];
  int           cyc_log[$];
  logic [N-1:0] fire;
  logic         stall;
  logic [63:0]  held;
  int           cyc = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(logic [DW-1:0] d, logic s, logic e,
                                     logic [EW-1:0] m, logic [SW-1:0] src);
    return {26'd0, src, m, s, e, d};
  endfunction

  // Output-side checker and input-side expectation capture.
  always @(negedge clk) begin
    logic [63:0] obs;
    logic [63:0] e;
    cyc++;
    obs = pk(out_data, out_startofpacket, out_endofpacket, out_empty, out_src);
    if (rst) begin
      fire  = '0;
      stall = 1'b0;
      sb.delete();
    end else begin
      chk("onehot", 64'($countones(in_ready) <= 1), 64'd1);
      if (stall) chk("hold", obs, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("beat", obs, e);
        end
        src_log.push_back(int'(out_src));
        cyc_log.push_back(cyc);
      end
      stall = out_valid && !out_ready;
      held  = obs;
      for (int i = 0; i < N; i++) begin
        fire[i] = in_valid[i] && in_ready[i];
        if (fire[i])
          sb.push_back(pk(in_data[i*DW +: DW], in_startofpacket[i],
                          in_endofpacket[i], in_empty[i*EW +: EW], SW'(i)));
      end
    end
  end

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) begin
        in_valid[i]         = 1'b1;
        in_data[i*DW +: DW] = lane_q[i][0].d;
        in_startofpacket[i] = lane_q[i][0].sop;
        in_endofpacket[i]   = lane_q[i][0].eop;
        in_empty[i*EW +: EW] = lane_q[i][0].emp;
      end else begin
        in_valid[i]         = 1'b0;
        in_data[i*DW +: DW] = '0;
        in_startofpacket[i] = 1'b0;
        in_endofpacket[i]   = 1'b0;
        in_empty[i*EW +: EW] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (fire[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
    refresh();
    #1;
  endtask

  task automatic send(int lane, int id, int nb, bit nosop, bit midsop);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.d   = {8'(lane), 8'(id), 16'(k)};
      b.sop = (k == 0 && !nosop) || (midsop && k == 2);
      b.eop = (k == nb - 1);
      b.emp = (k == nb - 1) ? EW'(nb) : '0;
      lane_q[lane].push_back(b);
    end
    refresh();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (lane_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      if (all_empty() && sb.size() == 0 && !out_valid) done = 1'b1;
      else tick();
    end
    chk("drain", 64'(done), 64'd1);
  endtask

  task automatic wait_lane(int lane, int left, int budget);
    for (int k = 0; k < budget && lane_q[lane].size() > left; k++) tick();
    chk("lane_wait", 64'(lane_q[lane].size()), 64'(left));
  endtask

  function automatic logic [63:0] seq(int b, int n);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = (s << 2) | ((b + i < src_log.size()) ? 64'(src_log[b+i]) : 64'hF);
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int  b;
    bit  done;
    rst = 1'b1;
    out_ready = 1'b1;
    out_almost_full = 1'b0;
    in_data = '0;
    in_valid = '0;
    in_startofpacket = '0;
    in_endofpacket = '0;
    in_empty = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out", pk(out_data, out_startofpacket, out_endofpacket,
                      out_empty, out_src), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);

    tick();
    b = src_log.size();
    for (int l = 0; l < N; l++) send(l, 16 + l, 3, 1'b0, 1'b0);
    wait_drain(60);
    chk("t1_seq", seq(b, 12), 64'h015ABF);
    chk("t1_cnt", 64'(src_log.size() - b), 64'd12);
    if (src_log.size() >= b + 12)
      chk("t1_cyc", 64'(cyc_log[b+11] - cyc_log[b]), 64'd11);

    b = src_log.size();
    send(1, 32, 4, 1'b0, 1'b0);
    wait_lane(1, 2, 20);
    send(0, 33, 2, 1'b0, 1'b0);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      chk("t2_blk", 64'(in_ready[0]), 64'd0);
      if (in_valid[1] && in_ready[1] && in_endofpacket[1]) done = 1'b1;
      tick();
    end
    chk("t2_eop", 64'(done), 64'd1);
    @(negedge clk);
    chk("t2_gnt", 64'(in_ready[0]), 64'd1);
    wait_drain(40);
    chk("t2_seq", seq(b, 6), 64'h550);

    b = src_log.size();
    send(2, 48, 5, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      out_ready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
    end
    out_ready = 1'b1;
    wait_drain(40);
    chk("t4_seq", seq(b, 5), 64'h2AA);
    chk("t4_cnt", 64'(src_log.size() - b), 64'd5);

    b = src_log.size();
    out_almost_full = 1'b1;
    send(3, 64, 3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_gate", 64'(in_ready), 64'd0);
      chk("t3_nov", 64'(out_valid), 64'd0);
      tick();
    end
    out_almost_full = 1'b0;
    wait_lane(3, 2, 10);
    out_almost_full = 1'b1;
    send(0, 65, 2, 1'b0, 1'b0);
    wait_lane(3, 0, 10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stop", 64'(in_ready), 64'd0);
      tick();
    end
    chk("t3_hold", 64'(lane_q[0].size()), 64'd2);
    out_almost_full = 1'b0;
    wait_drain(40);
    chk("t3_seq", seq(b, 5), 64'h3F0);

    chk("t5_perr0", 64'(proto_err), 64'd0);
    send(2, 80, 1, 1'b1, 1'b0);
    wait_drain(20);
    chk("t5_perr1", 64'(proto_err), 64'd1);
    b = src_log.size();
    send(3, 81, 4, 1'b0, 1'b1);
    send(0, 82, 2, 1'b0, 1'b0);
    wait_drain(40);
    chk("t5_seq", seq(b, 6), 64'hFF0);
    chk("t5_perr2", 64'(proto_err), 64'd1);

    send(1, 96, 4, 1'b0, 1'b0);
    wait_lane(1, 2, 20);
    rst = 1'b1;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    refresh();
    tick();
    @(negedge clk);
    chk("t6_vld", 64'(out_valid), 64'd0);
    chk("t6_rdy", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_perr", 64'(proto_err), 64'd0);
    tick();
    b = src_log.size();
    for (int l = N - 1; l >= 0; l--) send(l, 112 + l, 2, 1'b0, 1'b0);
    wait_drain(60);
    chk("t6_seq", seq(b, 8), 64'h05AF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
